// File: rtl/lcd_nibble_writer_pkg.sv
// -----------------------------------------------------------------------------
// lcd_nibble_writer_pkg
// Shared definitions for the HD44780-style 4-bit LCD writer:
//   - `define constants for the 3-bit FSM state encodings and for the
//     clear/home command codes that need the long settle time
//   - lcd_state_t : FSM state type built from those encodings
//   - CNT_W       : width of the settle/pulse delay counter
//   - is_long_cmd : identifies commands that need the long settle wait
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef LCD_NIBBLE_WRITER_DEFINITIONS
`define LCD_NIBBLE_WRITER_DEFINITIONS
`define LCD_ST_IDLE      3'd0
`define LCD_ST_SETUP_H   3'd1
`define LCD_ST_PULSE_H   3'd2
`define LCD_ST_GAP       3'd3
`define LCD_ST_SETUP_L   3'd4
`define LCD_ST_PULSE_L   3'd5
`define LCD_ST_SETTLE    3'd6
`define LCD_CMD_CLEAR    8'h01
`define LCD_CMD_HOME     8'h02
`define LCD_CMD_HOME_ALT 8'h03
`endif

package lcd_nibble_writer_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = `LCD_ST_IDLE,
        ST_SETUP_H = `LCD_ST_SETUP_H,
        ST_PULSE_H = `LCD_ST_PULSE_H,
        ST_GAP     = `LCD_ST_GAP,
        ST_SETUP_L = `LCD_ST_SETUP_L,
        ST_PULSE_L = `LCD_ST_PULSE_L,
        ST_SETTLE  = `LCD_ST_SETTLE
    } lcd_state_t;

    // Clear display and return home run for far longer inside the LCD
    // controller than every other instruction; they only count as commands
    // when RS selects the instruction register.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == `LCD_CMD_CLEAR) ||
                       (data == `LCD_CMD_HOME)  ||
                       (data == `LCD_CMD_HOME_ALT));
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// -----------------------------------------------------------------------------
// lcd_delay_counter
// Loadable down-counter that times each FSM state.
// Loading N makes oExpired rise in the N-th cycle after the load edge, i.e.
// in the last cycle of an N-cycle interval (N >= 1).
// Ports:
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous active-high reset (counter -> 0)
//   iLoad    in   load iCount on this edge (start of a new interval)
//   iCount   in   interval length in cycles, 1..2^20-1
//   oExpired out  high in the final cycle of the interval
// -----------------------------------------------------------------------------
module lcd_delay_counter
    import lcd_nibble_writer_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iLoad,
    input  logic [CNT_W-1:0] iCount,
    output logic             oExpired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Loading N-1 means the count reads N-1, N-2, ... 0 over N cycles, so the
    // zero that flags expiry lands exactly in the last cycle. Once at zero the
    // counter parks there instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (iLoad) begin
            cnt_d = iCount - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oExpired = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// -----------------------------------------------------------------------------
// lcd_nibble_writer
// Sends one byte to an HD44780-style LCD over its 4-bit bus: upper nibble,
// then lower nibble, each framed by setup / enable pulse timing, followed by
// a settle wait (long for clear/home commands).
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   iData[7:0] in   byte to send (command or character)
//   iRS        in   register select: 0 = command, 1 = data
//   iValid     in   request strobe, taken when oReady = 1
//   oReady     out  idle and able to accept a byte
//   oDone      out  one-cycle pulse in the first idle cycle after a byte
//   oLCD_E     out  LCD enable strobe (registered)
//   oLCD_RS    out  LCD register select
//   oLCD_RW    out  LCD read/write, always 0 (write only)
//   oLCD_Data  out  LCD data nibble DB7..DB4
// -----------------------------------------------------------------------------
module lcd_nibble_writer
    import lcd_nibble_writer_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES     = 2,
    parameter int unsigned ENABLE_CYCLES    = 12,
    parameter int unsigned GAP_CYCLES       = 50,
    parameter int unsigned WAIT_CYCLES      = 2000,
    parameter int unsigned LONG_WAIT_CYCLES = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    localparam logic [CNT_W-1:0] SETUP_C     = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] ENABLE_C    = CNT_W'(ENABLE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C       = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_C      = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_WAIT_C = CNT_W'(LONG_WAIT_CYCLES);

    lcd_state_t       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             rs_q, rs_d;
    logic             e_q, e_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [3:0]       nib_q, nib_d;
    logic             done_q, done_d;

    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_expired;

    lcd_delay_counter u_delay (
        .Clock    (Clock),
        .Reset    (Reset),
        .iLoad    (cnt_load),
        .iCount   (cnt_value),
        .oExpired (cnt_expired)
    );

    // Ready is gated by Reset so nothing looks acceptable while reset is held.
    assign oReady = (state_q == ST_IDLE) && !Reset;

    // Next-state logic: a fixed ring of states, each timed state leaving when
    // the delay counter reports its last cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP_H;
                end
            end
            ST_SETUP_H: if (cnt_expired) state_d = ST_PULSE_H;
            ST_PULSE_H: if (cnt_expired) state_d = ST_GAP;
            ST_GAP:     if (cnt_expired) state_d = ST_SETUP_L;
            ST_SETUP_L: if (cnt_expired) state_d = ST_PULSE_L;
            ST_PULSE_L: if (cnt_expired) state_d = ST_SETTLE;
            ST_SETTLE:  if (cnt_expired) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Byte/RS capture and delay-counter loading. The counter is reloaded on
    // every state change with the duration of the state being entered. The
    // settle length can use the captured byte because SETTLE is only entered
    // long after capture.
    always_comb begin
        byte_d    = accept ? iData : byte_q;
        rs_d      = accept ? iRS   : rs_q;
        cnt_load  = (state_d != state_q);
        cnt_value = {{(CNT_W-1){1'b0}}, 1'b1};
        unique case (state_d)
            ST_SETUP_H, ST_SETUP_L: cnt_value = SETUP_C;
            ST_PULSE_H, ST_PULSE_L: cnt_value = ENABLE_C;
            ST_GAP:                 cnt_value = GAP_C;
            ST_SETTLE:              cnt_value = is_long_cmd(rs_q, byte_q) ? LONG_WAIT_C
                                                                          : WAIT_C;
            default:                cnt_value = {{(CNT_W-1){1'b0}}, 1'b1};
        endcase
    end

    // LCD outputs are decoded from the upcoming state and registered, so each
    // pin changes cleanly on the same edge as the state it belongs to. byte_d
    // is used so the first nibble appears on the acceptance edge itself.
    always_comb begin
        e_d      = (state_d == ST_PULSE_H) || (state_d == ST_PULSE_L);
        lcd_rs_d = (state_d != ST_IDLE) ? rs_d : 1'b0;
        done_d   = (state_q == ST_SETTLE) && (state_d == ST_IDLE);
        nib_d    = 4'h0;
        unique case (state_d)
            ST_SETUP_H, ST_PULSE_H, ST_GAP:    nib_d = byte_d[7:4];
            ST_SETUP_L, ST_PULSE_L, ST_SETTLE: nib_d = byte_d[3:0];
            default:                           nib_d = 4'h0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            byte_q   <= 8'h00;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
            lcd_rs_q <= 1'b0;
            nib_q    <= 4'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            e_q      <= e_d;
            lcd_rs_q <= lcd_rs_d;
            nib_q    <= nib_d;
            done_q   <= done_d;
        end
    end

    assign oDone     = done_q;
    assign oLCD_E    = e_q;
    assign oLCD_RS   = lcd_rs_q;
    assign oLCD_RW   = 1'b0;
    assign oLCD_Data = nib_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_nibble_writer
// Self-checking bench for lcd_nibble_writer with short timing parameters.
// Expected pin behaviour per cycle is derived from the byte, RS and the
// timing parameters by plain arithmetic on the cycle offset from acceptance.
// -----------------------------------------------------------------------------
module tb_lcd_nibble_writer;

    localparam int S  = 2;
    localparam int EN = 3;
    localparam int G  = 4;
    localparam int W  = 5;
    localparam int LW = 9;

    logic       clk;
    logic       rst;
    logic [7:0] iData;
    logic       iRS;
    logic       iValid;
    logic       oReady;
    logic       oDone;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_Data;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_nibble_writer #(
        .SETUP_CYCLES     (S),
        .ENABLE_CYCLES    (EN),
        .GAP_CYCLES       (G),
        .WAIT_CYCLES      (W),
        .LONG_WAIT_CYCLES (LW)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .iData     (iData),
        .iRS       (iRS),
        .iValid    (iValid),
        .oReady    (oReady),
        .oDone     (oDone),
        .oLCD_E    (oLCD_E),
        .oLCD_RS   (oLCD_RS),
        .oLCD_RW   (oLCD_RW),
        .oLCD_Data (oLCD_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: clear (01), home (02/03) as commands wait long.
    function automatic int settle_len(input logic [7:0] d, input logic r);
        return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LW : W;
    endfunction

    function automatic int byte_len(input logic [7:0] d, input logic r);
        return 2*S + 2*EN + G + settle_len(d, r);
    endfunction

    // Place a request on the inputs at a falling edge.
    task automatic present(input logic [7:0] d, input logic r);
        @(negedge clk);
        iValid = 1'b1;
        iData  = d;
        iRS    = r;
    endtask

    // Runs one accepted byte from its acceptance edge to oDone, checking
    // every cycle. Expects its request already presented at a falling edge.
    // intrude: pulse iValid with 8'hFF during the first enable pulse.
    // hold_valid: keep iValid high and present (nd, nr) in the oDone cycle.
    task automatic run_byte(input logic [7:0] d, input logic r, input bit intrude,
                            input bit hold_valid, input logic [7:0] nd, input logic nr);
        int         len;
        int         p1, p2, p3, p4;
        logic       exp_e, exp_rs, exp_done;
        logic [3:0] exp_nib;
        len = byte_len(d, r);
        p1  = S;           // first enable pulse starts
        p2  = S + EN;      // gap starts
        p3  = 2*S + EN + G;// second enable pulse starts
        p4  = p3 + EN;     // settle starts
        n_checks++;
        if (oReady !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_%h: oReady=%b required 1", d, oReady);
        end
        @(posedge clk);
        for (int t = 0; t <= len; t++) begin
            @(negedge clk);
            exp_e    = ((t >= p1) && (t < p2)) || ((t >= p3) && (t < p4));
            exp_nib  = (t < p2 + G) ? d[7:4] : ((t < len) ? d[3:0] : 4'h0);
            exp_rs   = (t < len) ? r : 1'b0;
            exp_done = (t == len);
            n_checks++;
            if (oLCD_E !== exp_e) begin
                n_fail++;
                $display("FAIL e_%h_t%0d: oLCD_E=%b required %b", d, t, oLCD_E, exp_e);
            end
            n_checks++;
            if (oLCD_Data !== exp_nib) begin
                n_fail++;
                $display("FAIL data_%h_t%0d: oLCD_Data=%h required %h", d, t, oLCD_Data, exp_nib);
            end
            n_checks++;
            if (oLCD_RS !== exp_rs) begin
                n_fail++;
                $display("FAIL rs_%h_t%0d: oLCD_RS=%b required %b", d, t, oLCD_RS, exp_rs);
            end
            n_checks++;
            if (oDone !== exp_done) begin
                n_fail++;
                $display("FAIL done_%h_t%0d: oDone=%b required %b", d, t, oDone, exp_done);
            end
            n_checks++;
            if (oReady !== exp_done) begin
                n_fail++;
                $display("FAIL ready_%h_t%0d: oReady=%b required %b", d, t, oReady, exp_done);
            end
            // Input activity while busy must have no effect.
            if (t == 0) begin
                iValid = hold_valid;
                iData  = 8'($urandom);
                iRS    = 1'($urandom);
            end
            if (intrude && t == p1) begin
                iValid = 1'b1;
                iData  = 8'hFF;
                iRS    = 1'($urandom);
            end
            if (intrude && t == p1 + 1) iValid = 1'b0;
            if (hold_valid && t > 0 && t < len) iData = 8'($urandom);
            if (hold_valid && t == len) begin
                iData = nd;
                iRS   = nr;
            end
        end
        if (!hold_valid) begin
            @(negedge clk);
            n_checks++;
            if (oDone !== 1'b0 || oReady !== 1'b1) begin
                n_fail++;
                $display("FAIL after_%h: oDone=%b oReady=%b required 0/1", d, oDone, oReady);
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        iValid = 1'b0;
        iData  = 8'h00;
        iRS    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({oLCD_E, oLCD_RS, oLCD_Data, oDone, oLCD_RW} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: E=%b RS=%b D=%h Done=%b RW=%b required all 0",
                     oLCD_E, oLCD_RS, oLCD_Data, oDone, oLCD_RW);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (oReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: oReady=%b required 1", oReady);
        end
    endtask

    task automatic test_data_byte();
        present(8'h41, 1'b1);
        run_byte(8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_commands();
        logic [7:0] cmds [5] = '{8'h01, 8'h28, 8'h02, 8'h03, 8'h01};
        logic       rss  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            present(cmds[i], rss[i]);
            run_byte(cmds[i], rss[i], 1'b0, 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        present(8'h48, 1'b1);
        run_byte(8'h48, 1'b1, 1'b0, 1'b1, 8'h49, 1'b1);
        run_byte(8'h49, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (oLCD_RW !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_tied: oLCD_RW=%b required 0", oLCD_RW);
        end
    endtask

    task automatic test_ignore_valid();
        present(8'h30, 1'b1);
        run_byte(8'h30, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       r;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            r = 1'($urandom);
            if (i % 3 == 0) begin
                d = 8'($urandom_range(1, 3));
                r = 1'b0;
            end
            present(d, r);
            run_byte(d, r, (i % 4 == 1), 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_reset_abort();
        present(8'hA7, 1'b1);
        @(posedge clk);
        for (int t = 0; t <= 2*S + EN + G + 1; t++) begin
            @(negedge clk);
            if (t == 0) iValid = 1'b0;
        end
        n_checks++;
        if (oLCD_E !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_pulse: oLCD_E=%b required 1", oLCD_E);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({oLCD_E, oLCD_RS, oLCD_Data, oDone} !== 7'h00) begin
            n_fail++;
            $display("FAIL abort_async: E=%b RS=%b D=%h Done=%b required all 0",
                     oLCD_E, oLCD_RS, oLCD_Data, oDone);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (oReady !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: oReady=%b required 1", oReady);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (oDone !== 1'b0 || oLCD_E !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet_%0d: oDone=%b oLCD_E=%b required 0/0", i, oDone, oLCD_E);
            end
        end
        present(8'h55, 1'b1);
        run_byte(8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_data_byte();
        test_commands();
        test_back_to_back();
        test_ignore_valid();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
